// File: rtl/gray_fetch_pkg.sv
// gray_fetch_pkg: state encoding, drain length and default frame geometry for gray_fetcher
package gray_fetch_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
   localparam int DRAIN_CYCLES = 2;
   localparam int IMG_W_DEF    = 128;
   localparam int IMG_H_DEF    = 128;
   localparam int ADDR_W_DEF   = 14;
   localparam int DATA_W_DEF   = 8;
endpackage

// File: rtl/up_counter.sv
// up_counter: counter with synchronous clear taking priority over enable
module up_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk)
      if (rst || clr) q <= '0;
      else if (en) q <= q + 1'b1;
endmodule

// File: rtl/gray_fetcher.sv
// gray_fetcher: raster-scan reader of the host gray image, streaming row/col-tagged pixels.
// Defining GRAY_FETCH_STALL_EN adds a stall input that pauses requests while fetching.
module gray_fetcher
   import gray_fetch_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int COL_W  = $clog2(IMG_W),
   parameter int ROW_W  = $clog2(IMG_H)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gray_ready,
`ifdef GRAY_FETCH_STALL_EN
   input  logic              stall,
`endif
   output logic              gray_req,
   output logic [ADDR_W-1:0] gray_addr,
   input  logic [DATA_W-1:0] gray_data,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   output logic [COL_W-1:0]  pix_col,
   output logic [ROW_W-1:0]  pix_row,
   output logic              frame_done
);
   localparam int NPIX = IMG_W * IMG_H;
   state_t state_q, state_d;
   logic armed_q, armed_d;
   logic [1:0] drn_q, drn_d;
   logic [ADDR_W-1:0] count_q;
   logic last_req, col_wrap;
   logic [COL_W-1:0] col_q, col_d, col1_q, pix_col_q;
   logic [ROW_W-1:0] row_q, row_d, row1_q, pix_row_q;
   logic v1_q, pix_valid_q;
   logic [DATA_W-1:0] pix_data_q;
`ifdef GRAY_FETCH_STALL_EN
   assign gray_req = state_q == FETCH && !stall;
`else
   assign gray_req = state_q == FETCH;
`endif
   assign gray_addr  = count_q;
   assign last_req   = gray_req && count_q == ADDR_W'(NPIX - 1);
   assign frame_done = state_q == DONE;
   assign pix_valid  = pix_valid_q;
   assign pix_data   = pix_data_q;
   assign pix_col    = pix_col_q;
   assign pix_row    = pix_row_q;
   up_counter #(.WIDTH(ADDR_W)) u_addr_cnt (
      .clk(clk),
      .rst(rst),
      .en (gray_req),
      .clr(last_req),
      .q  (count_q)
   );
   // Request-side tags track the address counter so they wrap with it at frame end.
   assign col_wrap = col_q == COL_W'(IMG_W - 1);
   assign col_d = !gray_req ? col_q : col_wrap ? '0 : col_q + 1'b1;
   assign row_d = !(gray_req && col_wrap) ? row_q :
                  row_q == ROW_W'(IMG_H - 1) ? '0 : row_q + 1'b1;
   always_comb begin
      state_d = state_q == IDLE  ? (gray_ready && armed_q ? FETCH : IDLE) :
                state_q == FETCH ? (last_req ? DRAIN : FETCH) :
                state_q == DRAIN ? (drn_q == 2'(DRAIN_CYCLES - 1) ? DONE : DRAIN) : IDLE;
      armed_d = !gray_ready || (armed_q && state_q != IDLE);
      drn_d   = state_q == DRAIN ? drn_q + 2'd1 : 2'd0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         armed_q     <= 1'b1;
         drn_q       <= '0;
         col_q       <= '0;
         row_q       <= '0;
         v1_q        <= 1'b0;
         col1_q      <= '0;
         row1_q      <= '0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
         pix_col_q   <= '0;
         pix_row_q   <= '0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         drn_q       <= drn_d;
         col_q       <= col_d;
         row_q       <= row_d;
         v1_q        <= gray_req;
         col1_q      <= col_q;
         row1_q      <= row_q;
         pix_valid_q <= v1_q;
         if (v1_q) begin
            pix_data_q <= gray_data;
            pix_col_q  <= col1_q;
            pix_row_q  <= row1_q;
         end
      end
   end
endmodule
